// File: rtl/config_pkg.sv
// Core-wide CSR bus types shared by every CSR-mapped peripheral.
package config_pkg;
  typedef logic [31:0] word;
  typedef logic [4:0]  r;
  typedef logic [11:0] CsrAddrT;
endpackage

// File: rtl/decoder_pkg.sv
// CSR operation encoding produced by the instruction decoder.
package decoder_pkg;
  typedef enum logic [2:0] {
    CSR_RW  = 3'd1,
    CSR_RS  = 3'd2,
    CSR_RC  = 3'd3,
    CSR_RWI = 3'd5,
    CSR_RSI = 3'd6,
    CSR_RCI = 3'd7
  } csr_op_t;
endpackage

// File: rtl/uart_pkg.sv
// Shared types, register field positions and default addresses for the CSR UART transmitter.
package uart_pkg;
  import config_pkg::*;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2, PAR_NONE3 = 2'd3} ParityT;

  localparam int CfgPreLsb  = 0;
  localparam int CfgPreMsb  = 15;
  localparam int CfgParLsb  = 16;
  localparam int CfgParMsb  = 17;
  localparam int CfgStop    = 18;
  localparam int CfgBitsLsb = 19;
  localparam int CfgBitsMsb = 21;
  localparam word CfgWriteMask = 32'h003F_FFFF;

  localparam int StatBusy = 29;
  localparam int StatFull = 30;
  localparam int StatOvf  = 31;

  localparam CsrAddrT DefDataAddr = 12'h051;
  localparam CsrAddrT DefCfgAddr  = 12'h052;
  localparam CsrAddrT DefStatAddr = 12'h053;

  // Index of the last data bit; encodings 4-7 saturate to 8 data bits.
  function automatic logic [2:0] data_msb(logic [2:0] enc);
    return enc[2] ? 3'd7 : ({1'b0, enc[1:0]} + 3'd4);
  endfunction

  function automatic logic [7:0] data_mask(logic [2:0] msb);
    return 8'hFF >> (3'd7 - msb);
  endfunction

  function automatic word cfg_default(logic [15:0] prescaler);
    word w;
    w = '0;
    w[CfgPreMsb:CfgPreLsb]   = prescaler;
    w[CfgBitsMsb:CfgBitsLsb] = 3'd3;
    return w;
  endfunction
endpackage

// File: rtl/uart_tx_csr_if.sv
// CSR bus bundle between the decoder (master) and a CSR-mapped peripheral (slave).
interface uart_tx_csr_if
  import config_pkg::*, decoder_pkg::*;
();
  logic    csr_enable;
  CsrAddrT csr_addr;
  csr_op_t csr_op;
  r        rs1_zimm;
  word     rs1_data;
  word     csr_out;

  modport master (output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data, input csr_out);
  modport slave  (input csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data, output csr_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// Character FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(Depth);

  logic [7:0]    mem [Depth];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == (AW+1)'(Depth));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_csr.sv
// CSR-mapped UART transmitter: data/cfg/status CSRs, character FIFO and frame serialiser.
//   state  | meaning
//   IDLE   | line high; pops the next character and latches Cfg
//   START  | start bit (0)
//   DATA   | data bits, LSB first
//   PARITY | parity bit, only when parity is enabled
//   STOP   | one or two stop bits (1)
module uart_tx_csr
  import config_pkg::*, decoder_pkg::*, uart_pkg::*;
#(
  parameter int          Depth          = 8,
  parameter CsrAddrT     DataAddr       = DefDataAddr,
  parameter CsrAddrT     CfgAddr        = DefCfgAddr,
  parameter CsrAddrT     StatAddr       = DefStatAddr,
  parameter logic [15:0] ResetPrescaler = 16'd0
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_csr_if.slave  bus,
  output logic          tx,
  output logic          done_irq
);
  localparam int CW = $clog2(Depth) + 1;

  word           operand;
  word           cfg;
  word           cfg_wr;
  word           stat;
  logic          cfg_sel;
  logic          stat_sel;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    fifo_data;
  logic [CW-1:0] count;

  state_t        state;
  state_t        state_next;
  logic [15:0]   pre_q;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_en;
  logic          par_bit;
  logic          stop_cnt;
  logic          bit_end;
  logic [2:0]    cfg_msb;
  ParityT        cfg_par;

  always_comb begin
    operand  = (bus.csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'd0, bus.rs1_zimm} : bus.rs1_data;
    push     = bus.csr_enable && (bus.csr_addr == DataAddr);
    cfg_sel  = bus.csr_enable && (bus.csr_addr == CfgAddr);
    stat_sel = bus.csr_enable && (bus.csr_addr == StatAddr);
    ovf_clr  = stat_sel && (bus.csr_op inside {CSR_RC, CSR_RCI}) && operand[StatOvf];
    case (bus.csr_op)
      CSR_RW, CSR_RWI: cfg_wr = operand;
      CSR_RS, CSR_RSI: cfg_wr = cfg | operand;
      CSR_RC, CSR_RCI: cfg_wr = cfg & ~operand;
      default:         cfg_wr = cfg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg      <= cfg_default(ResetPrescaler);
      overflow <= 1'b0;
    end else begin
      if (cfg_sel) cfg <= cfg_wr & CfgWriteMask;
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  uart_tx_fifo #(.Depth(Depth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (operand[7:0]),
    .rdata (fifo_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    stat              = '0;
    stat[CW-1:0]      = count;
    stat[StatBusy]    = (state != IDLE);
    stat[StatFull]    = full;
    stat[StatOvf]     = overflow;
    bus.csr_out       = '0;
    if (bus.csr_addr == CfgAddr)       bus.csr_out = cfg;
    else if (bus.csr_addr == StatAddr) bus.csr_out = stat;
  end

  always_comb begin
    cfg_msb    = data_msb(cfg[CfgBitsMsb:CfgBitsLsb]);
    cfg_par    = ParityT'(cfg[CfgParMsb:CfgParLsb]);
    bit_end    = (baud_cnt == '0);
    state_next = state;
    pop        = 1'b0;
    tx         = 1'b1;
    done_irq   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end && bit_cnt == '0) state_next = par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx = par_bit;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && !stop_cnt) begin
          state_next = IDLE;
          done_irq   = empty;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Cfg fields are captured at pop so mid-frame writes only affect later frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pre_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        pre_q    <= cfg[CfgPreMsb:CfgPreLsb];
        baud_cnt <= cfg[CfgPreMsb:CfgPreLsb];
        bit_cnt  <= cfg_msb;
        shreg    <= fifo_data;
        par_en   <= (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
        par_bit  <= (^(fifo_data & data_mask(cfg_msb))) ^ (cfg_par == PAR_ODD);
        stop_cnt <= cfg[CfgStop];
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? pre_q : baud_cnt - 16'd1;
        if (bit_end && state == DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt - 3'd1;
        end
        if (bit_end && state == STOP) stop_cnt <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_csr.sv
// Bench for uart_tx_csr: queue-based frame model checked every cycle plus directed literal checks.
module tb_uart_tx_csr;
  import decoder_pkg::*;

  localparam int          Depth    = 8;
  localparam logic [11:0] ADR_DATA = 12'h051;
  localparam logic [11:0] ADR_CFG  = 12'h052;
  localparam logic [11:0] ADR_STAT = 12'h053;
  localparam logic [31:0] CFG_RST  = 32'h0018_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic done_irq;

  uart_tx_csr_if bus();

  uart_tx_csr #(.Depth(Depth)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .tx       (tx),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit mon_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: FIFO contents, expected line waveform (one entry per cycle), Cfg and overflow.
  logic [7:0]  m_q[$];
  bit          m_wtx[$];
  bit          m_wlast[$];
  logic [31:0] m_cfg = CFG_RST;
  bit          m_ovf = 1'b0;
  logic [31:0] m_op;
  logic [31:0] m_stat;
  logic [31:0] m_exp_out;
  bit          m_exp_tx;
  bit          m_exp_done;
  bit          m_pop;
  logic [7:0]  m_ch;

  function automatic void add_frame(input logic [7:0] ch, input logic [31:0] cfg);
    int  pre;
    int  enc;
    int  n;
    int  par;
    bit  pb;
    bit  b[$];
    pre = int'(cfg[15:0]);
    enc = int'(cfg[21:19]);
    n   = (enc > 3) ? 8 : enc + 5;
    par = int'(cfg[17:16]);
    pb  = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(ch[i]);
      pb ^= ch[i];
    end
    if (par == 1) b.push_back(pb);
    if (par == 2) b.push_back(~pb);
    b.push_back(1'b1);
    if (cfg[18]) b.push_back(1'b1);
    foreach (b[k]) begin
      for (int c = 0; c <= pre; c++) begin
        m_wtx.push_back(b[k]);
        m_wlast.push_back(1'b0);
      end
    end
    m_wlast[m_wlast.size()-1] = 1'b1;
  endfunction

  always @(negedge clk) begin
    m_op = (bus.csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'd0, bus.rs1_zimm} : bus.rs1_data;
    m_exp_tx   = (m_wtx.size() > 0) ? m_wtx[0] : 1'b1;
    m_exp_done = (m_wtx.size() > 0) && m_wlast[0] && (m_q.size() == 0);
    m_stat     = 32'(m_q.size());
    m_stat[29] = (m_wtx.size() > 0);
    m_stat[30] = (m_q.size() == Depth);
    m_stat[31] = m_ovf;
    m_exp_out  = (bus.csr_addr == ADR_CFG) ? m_cfg : (bus.csr_addr == ADR_STAT) ? m_stat : 32'd0;
    if (mon_on) begin
      check("tx", 64'(tx), 64'(m_exp_tx));
      check("done_irq", 64'(done_irq), 64'(m_exp_done));
      check("csr_out", 64'(bus.csr_out), 64'(m_exp_out));
    end
    if (!reset) begin
      m_q.delete();
      m_wtx.delete();
      m_wlast.delete();
      m_cfg = CFG_RST;
      m_ovf = 1'b0;
    end else begin
      m_pop = (m_wtx.size() == 0) && (m_q.size() > 0);
      if (m_wtx.size() > 0) begin
        void'(m_wtx.pop_front());
        void'(m_wlast.pop_front());
      end
      if (m_pop) begin
        m_ch = m_q.pop_front();
        add_frame(m_ch, m_cfg);
      end
      if (bus.csr_enable) begin
        if (bus.csr_addr == ADR_STAT && (bus.csr_op inside {CSR_RC, CSR_RCI}) && m_op[31]) m_ovf = 1'b0;
        if (bus.csr_addr == ADR_DATA) begin
          if (m_q.size() < Depth) m_q.push_back(m_op[7:0]);
          else                    m_ovf = 1'b1;
        end
        if (bus.csr_addr == ADR_CFG) begin
          case (bus.csr_op)
            CSR_RW, CSR_RWI: m_cfg = m_op;
            CSR_RS, CSR_RSI: m_cfg = m_cfg | m_op;
            default:         m_cfg = m_cfg & ~m_op;
          endcase
          m_cfg &= 32'h003F_FFFF;
        end
      end
    end
  end

  task automatic csr_acc(input csr_op_t op, input logic [11:0] addr, input logic [31:0] data, input logic [4:0] zimm);
    bus.csr_enable = 1'b1;
    bus.csr_op     = op;
    bus.csr_addr   = addr;
    bus.rs1_data   = data;
    bus.rs1_zimm   = zimm;
    @(posedge clk);
    #1;
    bus.csr_enable = 1'b0;
    bus.csr_addr   = 12'h000;
    bus.rs1_data   = 32'd0;
    bus.rs1_zimm   = 5'd0;
  endtask

  task automatic peek(input logic [11:0] addr, output logic [31:0] v);
    bus.csr_addr = addr;
    @(negedge clk);
    v = bus.csr_out;
    @(posedge clk);
    #1;
    bus.csr_addr = 12'h000;
  endtask

  task automatic grab(input int n, output logic [63:0] v, output logic [63:0] dm);
    v  = '0;
    dm = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v[i]  = tx;
      dm[i] = done_irq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done_irq) begin
        n = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] v;
    logic [63:0] dm;
    logic [63:0] exp_v;
    logic [9:0]  fb;
    int          n;

    bus.csr_enable = 1'b0;
    bus.csr_addr   = 12'h000;
    bus.csr_op     = CSR_RW;
    bus.rs1_zimm   = 5'd0;
    bus.rs1_data   = 32'd0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    mon_on = 1'b1;

    // Reset state
    check("rst_tx", 64'(tx), 64'd1);
    peek(ADR_STAT, rd);
    check("rst_stat", 64'(rd), 64'h0);
    peek(ADR_CFG, rd);
    check("rst_cfg", 64'(rd), 64'h0018_0000);

    // 0x55, 8N1, one cycle per bit
    csr_acc(CSR_RW, ADR_DATA, 32'h55, 5'd0);
    grab(11, v, dm);
    check("t1_wave", v, 64'h555);
    check("t1_done", dm, 64'h400);

    // prescaler 3, even parity, 7 data bits, 0x41
    csr_acc(CSR_RW, ADR_CFG, 32'h0011_0003, 5'd0);
    csr_acc(CSR_RW, ADR_DATA, 32'h41, 5'd0);
    grab(42, v, dm);
    fb = 10'b1010000010;
    exp_v = '0;
    exp_v[0]  = 1'b1;
    exp_v[41] = 1'b1;
    for (int i = 1; i <= 40; i++) exp_v[i] = fb[(i-1)/4];
    check("t2_wave", v, exp_v);
    check("t2_done", dm, 64'h1 << 40);

    // Overflow: Depth+2 pushes with one popped into the serialiser
    csr_acc(CSR_RW, ADR_CFG, 32'h0018_0064, 5'd0);
    for (int i = 0; i < Depth + 2; i++) csr_acc(CSR_RW, ADR_DATA, 32'h60 + 32'(i), 5'd0);
    peek(ADR_STAT, rd);
    check("t3_stat_ovf", 64'(rd), 64'hE000_0008);
    csr_acc(CSR_RC, ADR_STAT, 32'h8000_0000, 5'd0);
    peek(ADR_STAT, rd);
    check("t3_stat_clr", 64'(rd), 64'h6000_0008);
    wait_done(10000, n);
    check("t3_done_at", 64'(n), 64'd9087);

    // Full FIFO, push in the same cycle as the serialiser pop
    csr_acc(CSR_RW, ADR_CFG, 32'h0018_0000, 5'd0);
    for (int i = 0; i < Depth + 1; i++) csr_acc(CSR_RW, ADR_DATA, 32'h30 + 32'(i), 5'd0);
    tick(3);
    csr_acc(CSR_RW, ADR_DATA, 32'hA5, 5'd0);
    peek(ADR_STAT, rd);
    check("t4_stat", 64'(rd), 64'h6000_0008);
    wait_done(500, n);
    check("t4_done_at", 64'(n), 64'd97);

    // Stop-bit change mid-frame only affects the next frame
    csr_acc(CSR_RW, ADR_DATA, 32'h0F, 5'd0);
    csr_acc(CSR_RW, ADR_DATA, 32'hF0, 5'd0);
    csr_acc(CSR_RW, ADR_CFG, 32'h001C_0000, 5'd0);
    grab(22, v, dm);
    check("t5_wave", v, 64'h3F_830F);
    check("t5_done", dm, 64'h10_0000);

    // Reset during DATA
    csr_acc(CSR_RW, ADR_DATA, 32'h00, 5'd0);
    csr_acc(CSR_RW, ADR_DATA, 32'h11, 5'd0);
    tick(3);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("t6_tx", 64'(tx), 64'd1);
    peek(ADR_STAT, rd);
    check("t6_stat", 64'(rd), 64'h0);
    peek(ADR_CFG, rd);
    check("t6_cfg", 64'(rd), 64'h0018_0000);
    grab(12, v, dm);
    check("t6_wave", v, 64'hFFF);
    check("t6_done", dm, 64'h0);

    // Set/clear ops on Cfg, ignored Stat write, immediate push
    csr_acc(CSR_RS, ADR_CFG, 32'h0001_0005, 5'd0);
    peek(ADR_CFG, rd);
    check("t7_cfg_rs", 64'(rd), 64'h0019_0005);
    csr_acc(CSR_RCI, ADR_CFG, 32'hFFFF_FFFF, 5'd1);
    peek(ADR_CFG, rd);
    check("t7_cfg_rci", 64'(rd), 64'h0019_0004);
    csr_acc(CSR_RW, ADR_STAT, 32'hFFFF_FFFF, 5'd0);
    peek(ADR_STAT, rd);
    check("t7_stat_ro", 64'(rd), 64'h0);
    csr_acc(CSR_RWI, ADR_DATA, 32'hFFFF_FFFF, 5'h15);
    wait_done(200, n);
    check("t7_done_at", 64'(n), 64'd56);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
